// File: rtl/serial_ripple_subtract.sv
// serial_ripple_subtract: bit-serial LSB-first ripple-borrow subtractor; one full-subtractor
// cell plus a borrow flop, result = WIDTH-bit difference with the final borrow in D[WIDTH].
module serial_ripple_subtract #(
   parameter int WIDTH = 4,
   localparam int CW = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   D
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   state_t state, next;
   logic [WIDTH-1:0] sh_a, sh_b;
   logic [WIDTH-2:0] acc;
   logic [WIDTH-1:0] full;
   logic [CW-1:0] cnt;
   logic borrow, d_bit, b_out, last, accept;
   always_comb begin
      d_bit  = sh_a[0] ^ sh_b[0] ^ borrow;
      b_out  = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & borrow);
      full   = {d_bit, acc};
      last   = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
      accept = start && (state != S_RUN);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IDLE;
      else state <= next;
   always_comb next = accept ? S_RUN : last ? S_DONE : (state == S_RUN) ? S_RUN : S_IDLE;
   always_comb begin
      busy = (state == S_RUN);
      done = (state == S_DONE);
   end
   // acc keeps only the upper WIDTH-1 bits; the bit processed last is appended directly into D
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sh_a   <= '0;
         sh_b   <= '0;
         acc    <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         D      <= '0;
      end else if (accept) begin
         sh_a   <= A;
         sh_b   <= B;
         acc    <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
      end else if (state == S_RUN) begin
         sh_a   <= sh_a >> 1;
         sh_b   <= sh_b >> 1;
         acc    <= full[WIDTH-1:1];
         borrow <= b_out;
         cnt    <= cnt + CW'(1);
         if (last) D <= {b_out, full};
      end
endmodule

// File: tb/tb_serial_ripple_subtract.sv
// tb_serial_ripple_subtract: scoreboard bench for the serial subtractor at WIDTH 4, 8 and 5
// (the 5-bit instance undoes a 4-bit addition to recover the first addend).
module tb_serial_ripple_subtract;
   logic clk = 1'b0, rst = 1'b1;
   logic start4 = 1'b0, start8 = 1'b0, start5 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [4:0] a5 = '0, b5 = '0;
   logic busy4, done4, busy8, done8, busy5, done5;
   logic [4:0] d4;
   logic [8:0] d8;
   logic [5:0] d5;
   logic [4:0] q4[$];
   logic [8:0] q8[$];
   logic [5:0] q5[$];
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   serial_ripple_subtract #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
      .busy(busy4), .done(done4), .D(d4));
   serial_ripple_subtract #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
      .busy(busy8), .done(done8), .D(d8));
   serial_ripple_subtract #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .start(start5), .A(a5), .B(b5),
      .busy(busy5), .done(done5), .D(d5));

   // advance negedges until the selected instance pulses done, bounded
   task automatic wait_done(input int w, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!((w == 4 && done4) || (w == 8 && done8) || (w == 5 && done5)) && cyc < 50);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if ({busy4, done4} !== 2'b00) begin bad++; $display("FAIL reset_flags4: got %b want 00", {busy4, done4}); end
      total++; if (d4 !== 5'd0) begin bad++; $display("FAIL reset_d4: got %b want 00000", d4); end
      total++; if ({busy8, done8, d8} !== 11'd0) begin bad++; $display("FAIL reset_w8: got %b want 0", {busy8, done8, d8}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [3:0] ta[5] = '{4'd9, 4'd7, 4'd0, 4'd15, 4'd0};
      logic [3:0] tb[5] = '{4'd7, 4'd9, 4'd0, 4'd0, 4'd15};
      logic [4:0] te[5] = '{5'b00010, 5'b11110, 5'b00000, 5'b01111, 5'b10001};
      logic [4:0] exp;
      int cyc;
      for (int i = 0; i < 5; i++) begin
         a4 = ta[i]; b4 = tb[i]; start4 = 1'b1;
         q4.push_back(te[i]);
         @(negedge clk);
         start4 = 1'b0;
         total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL basic_busy[%0d]: got %b want 1", i, busy4); end
         wait_done(4, cyc);
         exp = q4.pop_front();
         total++; if (cyc != 4) begin bad++; $display("FAIL basic_latency[%0d]: got %0d want 4", i, cyc); end
         total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL basic_busy_done[%0d]: got %b want 0", i, busy4); end
         total++; if (d4 !== exp) begin bad++; $display("FAIL basic_d[%0d]: got %b want %b", i, d4, exp); end
         @(negedge clk);
         total++; if ({done4, d4} !== {1'b0, exp}) begin bad++; $display("FAIL basic_hold[%0d]: got %b want %b", i, {done4, d4}, {1'b0, exp}); end
      end
   endtask

   task automatic test_ignore();
      logic [4:0] exp;
      int cyc;
      a4 = 4'd9; b4 = 4'd7; start4 = 1'b1;
      q4.push_back(5'b00010);
      @(negedge clk);
      a4 = 4'd3; b4 = 4'd1;
      @(negedge clk);
      a4 = 4'd12; b4 = 4'd14;
      @(negedge clk);
      start4 = 1'b0; a4 = 4'd5;
      wait_done(4, cyc);
      exp = q4.pop_front();
      total++; if (cyc != 2) begin bad++; $display("FAIL ignore_latency: got %0d want 2", cyc); end
      total++; if (d4 !== exp) begin bad++; $display("FAIL ignore_d: got %b want %b", d4, exp); end
      @(negedge clk);
      total++; if ({busy4, done4} !== 2'b00) begin bad++; $display("FAIL ignore_idle: got %b want 00", {busy4, done4}); end
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp;
      int cyc;
      a4 = 4'd9; b4 = 4'd7; start4 = 1'b1;
      q4.push_back(5'b00010);
      @(negedge clk);
      a4 = 4'd7; b4 = 4'd9;
      wait_done(4, cyc);
      exp = q4.pop_front();
      total++; if (cyc != 4) begin bad++; $display("FAIL b2b_latency1: got %0d want 4", cyc); end
      total++; if ({busy4, d4} !== {1'b0, exp}) begin bad++; $display("FAIL b2b_first: got %b want %b", {busy4, d4}, {1'b0, exp}); end
      q4.push_back(5'b11110);
      wait_done(4, cyc);
      exp = q4.pop_front();
      total++; if (cyc != 5) begin bad++; $display("FAIL b2b_period: got %0d want 5", cyc); end
      total++; if ({busy4, d4} !== {1'b0, exp}) begin bad++; $display("FAIL b2b_second: got %b want %b", {busy4, d4}, {1'b0, exp}); end
      start4 = 1'b0;
      @(negedge clk);
      total++; if ({busy4, done4, d4} !== {2'b00, exp}) begin bad++; $display("FAIL b2b_idle: got %b want %b", {busy4, done4, d4}, {2'b00, exp}); end
   endtask

   task automatic test_async_reset();
      logic [4:0] exp;
      int cyc;
      a4 = 4'd9; b4 = 4'd7; start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL arst_pre_busy: got %b want 1", busy4); end
      rst = 1'b1;
      #1;
      total++; if ({busy4, done4, d4} !== 7'd0) begin bad++; $display("FAIL arst_clear: got %b want 0000000", {busy4, done4, d4}); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
      q4.push_back(5'b00010);
      @(negedge clk);
      start4 = 1'b0;
      wait_done(4, cyc);
      exp = q4.pop_front();
      total++; if (cyc != 4) begin bad++; $display("FAIL arst_latency: got %0d want 4", cyc); end
      total++; if (d4 !== exp) begin bad++; $display("FAIL arst_d: got %b want %b", d4, exp); end
      @(negedge clk);
   endtask

   task automatic test_sweep4();
      logic [4:0] exp;
      int cyc;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++) begin
            a4 = 4'(i); b4 = 4'(j); start4 = 1'b1;
            q4.push_back(5'(i) - 5'(j));
            @(negedge clk);
            start4 = 1'b0;
            wait_done(4, cyc);
            exp = q4.pop_front();
            total++; if (cyc != 4 || d4 !== exp) begin bad++; $display("FAIL sweep4 %0d-%0d: got %b after %0d want %b after 4", i, j, d4, cyc, exp); end
         end
   endtask

   task automatic test_random8();
      logic [7:0] av, bv;
      logic [8:0] exp;
      int cyc;
      for (int i = 0; i < 40; i++) begin
         av = (i == 0) ? 8'd0 : (i == 1) ? 8'd255 : 8'($urandom);
         bv = (i == 0) ? 8'd255 : (i == 1) ? 8'd0 : 8'($urandom);
         a8 = av; b8 = bv; start8 = 1'b1;
         q8.push_back({1'b0, av} - {1'b0, bv});
         @(negedge clk);
         start8 = 1'b0;
         wait_done(8, cyc);
         exp = q8.pop_front();
         total++; if (cyc != 8 || d8 !== exp) begin bad++; $display("FAIL rand8 %0d-%0d: got %b after %0d want %b after 8", av, bv, d8, cyc, exp); end
      end
   endtask

   task automatic test_cross();
      logic [3:0] av, bv;
      logic [5:0] exp;
      int cyc;
      for (int i = 0; i < 32; i++) begin
         av = 4'($urandom); bv = 4'($urandom);
         a5 = {1'b0, av} + {1'b0, bv}; b5 = {1'b0, bv}; start5 = 1'b1;
         q5.push_back({2'b00, av});
         @(negedge clk);
         start5 = 1'b0;
         wait_done(5, cyc);
         exp = q5.pop_front();
         total++; if (cyc != 5 || d5 !== exp) begin bad++; $display("FAIL cross (%0d+%0d)-%0d: got %b after %0d want %b after 5", av, bv, bv, d5, cyc, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore();
      test_back_to_back();
      test_async_reset();
      test_sweep4();
      test_random8();
      test_cross();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_ripple_subtract.md
Name: serial_ripple_subtract

Overview:
- Bit-serial ripple-borrow subtractor: the inverse operation of the team's combinational ripple-carry adder.
- Captures two WIDTH-bit unsigned operands on a start strobe.
- Processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flop.
- Presents a (WIDTH+1)-bit result: difference plus final borrow in the MSB, matching the adder's sum-plus-carry format.

Parameters:
- WIDTH, 4, operand width in bits (≥2); result is WIDTH+1 bits.
- CW, $clog2(WIDTH)+1, bit-counter width (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  minuend; sampled with accepted start.
- B  input  WIDTH  subtrahend; sampled with accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse: D is newly valid.
- D  output  WIDTH+1  D[WIDTH-1:0] = (A-B) mod 2^WIDTH; D[WIDTH] = final borrow (1 iff A<B unsigned).

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0, done=0, D=0; borrow flop=0, bit counter=0, operand shift registers=0.
  - Effective immediately, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch A and B into shift registers, clear the borrow flop, set counter=0, go to RUN, busy=1.
  - start=0: remain in IDLE.
- RUN, each edge:
  - Take a=shA[0], b=shB[0], bi=borrow.
  - Difference bit d = a^b^bi.
  - Borrow out = (~a&b) | (~(a^b)&bi).
  - Shift d into the result register from the MSB side, toward LSB.
  - Shift shA and shB right by one; counter++.
  - On the edge processing bit WIDTH-1 (counter==WIDTH-1): go to DONE.
- DONE transition edge (the same edge that processes bit WIDTH-1):
  - D[WIDTH-1:0] loaded with the complete difference; D[WIDTH] = final borrow.
  - done=1, busy=0 after this edge.
- Latency: start sampled at edge 0; done=1 and D valid after edge WIDTH; done=0 after edge WIDTH+1.
- D holds its value until the next completed operation or reset; D never shows partial results.
- DONE lasts exactly one cycle, then the next state is decided:
  - start=1 in that cycle: accepted immediately (back-to-back), operands latched, state=RUN, busy=1, done=0.
  - start=0: state=IDLE.
- start while busy=1 (RUN): ignored; no effect on operands or result.
- A and B may change freely while busy=1; only the captured copies are used.
- Arithmetic identity: for all A, B, {D[WIDTH], D[WIDTH-1:0]} equals the (WIDTH+1)-bit two's-complement value A-B with WIDTH+1 bits of wrap, i.e. D = (A + ~B + 1) mod 2^(WIDTH+1) with operands zero-extended.
- No X propagation: all outputs are driven from flops after reset.

Test Plan:
- WIDTH=4, A=4'b1001, B=4'b0111, start pulsed at edge 0 → busy=1 edges 1-4; after edge 4, done=1, D=5'b00010; after edge 5, done=0, D unchanged.
- A=4'b0111, B=4'b1001 → D=5'b11110 (diff 14, borrow 1); A=0, B=0 → D=5'b00000; A=15, B=0 → D=5'b01111; A=0, B=15 → D=5'b10001.
- Second start held high during RUN with A=3, B=1 → ignored; the first result (9-7 → 5'b00010) completes on schedule. A and B toggled mid-RUN → result unaffected.
- start held high continuously → done pulses every 5 cycles, busy low exactly in each done cycle. Operands change every accept: 9-7, then 7-9 → D=00010, then 11110.
- rst asserted asynchronously (between edges) during RUN at bit 2 → busy, done, D go 0 immediately without a clock edge. After release, a new start with 5-3 → D=5'b00010 with normal latency.
- Exhaustive sweep, all 256 (A,B) pairs for WIDTH=4 plus random for WIDTH=8 → D equals a reference model of A-B in WIDTH+1 bits. Cross-check: feeding the adder sum back (S-B with a WIDTH+1-bit instance) recovers A.
